// File: rtl/mem_dma.sv
// mem_dma: word-by-word memory-to-memory copy engine driving one port of a
// dual-port synchronous RAM (read data valid one cycle after the address).
// Optional constant-fill mode is enabled by defining MEM_DMA_FILL_EN.
module mem_dma #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SIZE       = 1000,
  localparam int unsigned ADDR_W    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src,
  input  logic [ADDR_W-1:0]     dst,
  input  logic [ADDR_W-1:0]     len,
`ifdef MEM_DMA_FILL_EN
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fill_data,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3
`ifdef MEM_DMA_FILL_EN
    ,
    FILL  = 3'd4
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
`ifdef MEM_DMA_FILL_EN
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
`endif

  // Address increment that wraps at the memory depth, not at the pointer width.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(SIZE - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
`ifdef MEM_DMA_FILL_EN
      fill_data_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
`ifdef MEM_DMA_FILL_EN
      fill_data_q <= fill_data_d;
`endif
    end
  end

  // Next-state and pointer updates; outputs are derived from the next state so
  // the registered outputs line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
`ifdef MEM_DMA_FILL_EN
    fill_data_d = fill_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = DONE;
          end else begin
            src_d   = src;
            dst_d   = dst;
            cnt_d   = len;
            state_d = READ;
`ifdef MEM_DMA_FILL_EN
            if (fill) begin
              fill_data_d = fill_data;
              state_d     = FILL;
            end
`endif
          end
        end
      end
      READ: state_d = WRITE;
      WRITE: begin
        src_d   = addr_inc(src_q);
        dst_d   = addr_inc(dst_q);
        cnt_d   = cnt_q - ADDR_W'(1);
        state_d = (cnt_q == ADDR_W'(1)) ? DONE : READ;
      end
`ifdef MEM_DMA_FILL_EN
      FILL: begin
        dst_d   = addr_inc(dst_q);
        cnt_d   = cnt_q - ADDR_W'(1);
        state_d = (cnt_q == ADDR_W'(1)) ? DONE : FILL;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == READ) || (state_d == WRITE);
    done_d      = (state_d == DONE);
    mem_wr_en_d = (state_d == WRITE);
    mem_addr_d  = '0;
    if (state_d == READ)  mem_addr_d = src_d;
    if (state_d == WRITE) mem_addr_d = dst_d;
`ifdef MEM_DMA_FILL_EN
    if (state_d == FILL) begin
      busy_d      = 1'b1;
      mem_wr_en_d = 1'b1;
      mem_addr_d  = dst_d;
    end
`endif
  end

  // Write data: forwards the RAM read data during WRITE, since it only becomes
  // valid in that cycle; zero whenever no write is in progress.
  always_comb begin
    mem_wr_data = '0;
    if (state_q == WRITE) mem_wr_data = mem_rd_data;
`ifdef MEM_DMA_FILL_EN
    if (state_q == FILL) mem_wr_data = fill_data_q;
`endif
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_mem_dma.sv
// Directed testbench for mem_dma with a behavioural dual-port synchronous RAM.
module tb_mem_dma;
  localparam int unsigned DW = 16;
  localparam int unsigned SZ = 1000;
  localparam int unsigned AW = 10;

  logic          clk, rst_n, start;
  logic [AW-1:0] src, dst, len;
  logic          busy, done, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
`ifdef MEM_DMA_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_data;
`endif

  logic [DW-1:0] mem [0:SZ-1];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_wdata;

  int checks = 0;
  int errors = 0;

  // Results recorded by run_xfer
  int wr_count, done_count, done_cyc, first_wr_cyc;
  bit busy_seen, abort_zero;
  logic [AW-1:0] wr_addrs[$];
  logic [AW-1:0] rd_addrs[$];

  mem_dma #(.DATA_WIDTH(DW), .SIZE(SZ)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src(src), .dst(dst), .len(len),
`ifdef MEM_DMA_FILL_EN
    .fill(fill), .fill_data(fill_data),
`endif
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: DUT port has write priority; bench side port used for preloading.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    else if (tb_we) mem[tb_addr] <= tb_wdata;
    mem_rd_data <= mem[mem_addr];
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Launch a transfer and record activity for ncyc cycles after the start edge.
  task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] l, input logic f,
                          input logic [DW-1:0] fd, input int restart_n,
                          input int abort_n, input int ncyc, input bit release_rst);
    wr_count = 0; done_count = 0; done_cyc = -1; first_wr_cyc = -1;
    busy_seen = 0; abort_zero = 1;
    wr_addrs.delete(); rd_addrs.delete();
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    start = 1'b1; src = s; dst = d; len = l;
`ifdef MEM_DMA_FILL_EN
    fill = f; fill_data = fd;
`else
    if (f || (fd != '0)) $display("note: fill request ignored in this build");
`endif
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_wr_en) begin
        wr_count++;
        wr_addrs.push_back(mem_addr);
        if (first_wr_cyc < 0) first_wr_cyc = n;
      end
      if (busy && !mem_wr_en) rd_addrs.push_back(mem_addr);
      if (busy) busy_seen = 1;
      if (done) begin
        done_count++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (n == restart_n) begin start = 1'b1; dst = 10'd200; end
      if (n == abort_n) begin
        rst_n = 1'b0;
        #1;
        if (busy !== 1'b0 || done !== 1'b0 || mem_wr_en !== 1'b0 ||
            mem_addr !== '0 || mem_wr_data !== '0) abort_zero = 0;
      end
    end
`ifdef MEM_DMA_FILL_EN
    fill = 1'b0;
`endif
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    checks++; if (mem_wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", mem_wr_data); end
    // start presented together with reset release is taken on the first edge
    poke(10'd40, 16'h1234);
    run_xfer(10'd40, 10'd60, 10'd1, 1'b0, '0, 0, 0, 5, 1'b1);
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL reset_first_start_done_cyc: got %0d expected 3", done_cyc); end
    checks++; if (mem[60] !== 16'h1234) begin errors++; $display("FAIL reset_first_start_data: got %h expected 1234", mem[60]); end
  endtask

  task automatic test_copy();
    logic [DW-1:0] pat [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    for (int i = 0; i < 4; i++) poke(10'(10 + i), pat[i]);
    run_xfer(10'd10, 10'd100, 10'd4, 1'b0, '0, 0, 0, 14, 1'b0);
    checks++; if (wr_count !== 4) begin errors++; $display("FAIL copy_wr_count: got %0d expected 4", wr_count); end
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL copy_done_cyc: got %0d expected 9", done_cyc); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL copy_done_count: got %0d expected 1", done_count); end
    checks++; if (first_wr_cyc !== 2) begin errors++; $display("FAIL copy_first_wr_cyc: got %0d expected 2", first_wr_cyc); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[100 + i] !== pat[i]) begin errors++; $display("FAIL copy_data[%0d]: got %h expected %h", i, mem[100 + i], pat[i]); end
      checks++; if (wr_addrs[i] !== 10'(100 + i)) begin errors++; $display("FAIL copy_wr_addr[%0d]: got %0d expected %0d", i, wr_addrs[i], 100 + i); end
      checks++; if (rd_addrs[i] !== 10'(10 + i)) begin errors++; $display("FAIL copy_rd_addr[%0d]: got %0d expected %0d", i, rd_addrs[i], 10 + i); end
    end
  endtask

  task automatic test_zero_len();
    run_xfer(10'd5, 10'd7, 10'd0, 1'b0, '0, 0, 0, 5, 1'b0);
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cyc: got %0d expected 1", done_cyc); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_count); end
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL zero_wr_count: got %0d expected 0", wr_count); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy_seen); end
  endtask

  task automatic test_start_while_busy();
    poke(10'd0, 16'h1111); poke(10'd1, 16'h2222); poke(10'd2, 16'h3333);
    for (int i = 0; i < 3; i++) poke(10'(200 + i), 16'h5E5E);
    run_xfer(10'd0, 10'd50, 10'd3, 1'b0, '0, 2, 0, 12, 1'b0);
    checks++; if (done_count !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", done_count); end
    checks++; if (done_cyc !== 7) begin errors++; $display("FAIL busy_done_cyc: got %0d expected 7", done_cyc); end
    checks++; if (wr_count !== 3) begin errors++; $display("FAIL busy_wr_count: got %0d expected 3", wr_count); end
    checks++; if (mem[50] !== 16'h1111) begin errors++; $display("FAIL busy_data50: got %h expected 1111", mem[50]); end
    checks++; if (mem[51] !== 16'h2222) begin errors++; $display("FAIL busy_data51: got %h expected 2222", mem[51]); end
    checks++; if (mem[52] !== 16'h3333) begin errors++; $display("FAIL busy_data52: got %h expected 3333", mem[52]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[200 + i] !== 16'h5E5E) begin errors++; $display("FAIL busy_untouched[%0d]: got %h expected 5e5e", 200 + i, mem[200 + i]); end
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 8; i++) poke(10'(i), 16'(16'h0100 + i));
    for (int i = 302; i < 308; i++) poke(10'(i), 16'hDEAD);
    // second write lands on edge 4; reset is dropped in the following cycle
    run_xfer(10'd0, 10'd300, 10'd8, 1'b0, '0, 0, 5, 10, 1'b0);
    checks++; if (abort_zero !== 1'b1) begin errors++; $display("FAIL abort_outputs_zero: got %b expected 1", abort_zero); end
    checks++; if (wr_count !== 2) begin errors++; $display("FAIL abort_wr_count: got %0d expected 2", wr_count); end
    checks++; if (done_count !== 0) begin errors++; $display("FAIL abort_done_count: got %0d expected 0", done_count); end
    checks++; if (mem[300] !== 16'h0100) begin errors++; $display("FAIL abort_data300: got %h expected 0100", mem[300]); end
    checks++; if (mem[301] !== 16'h0101) begin errors++; $display("FAIL abort_data301: got %h expected 0101", mem[301]); end
    for (int i = 302; i < 308; i++) begin
      checks++; if (mem[i] !== 16'hDEAD) begin errors++; $display("FAIL abort_untouched[%0d]: got %h expected dead", i, mem[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ra [4] = '{10'd998, 10'd999, 10'd0, 10'd1};
    logic [DW-1:0] pat [4] = '{16'hE998, 16'hE999, 16'hE000, 16'hE001};
    for (int i = 0; i < 4; i++) poke(ra[i], pat[i]);
    run_xfer(10'd998, 10'd20, 10'd4, 1'b0, '0, 0, 0, 12, 1'b0);
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL wrap_done_cyc: got %0d expected 9", done_cyc); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_addrs[i] !== ra[i]) begin errors++; $display("FAIL wrap_rd_addr[%0d]: got %0d expected %0d", i, rd_addrs[i], ra[i]); end
      checks++; if (wr_addrs[i] !== 10'(20 + i)) begin errors++; $display("FAIL wrap_wr_addr[%0d]: got %0d expected %0d", i, wr_addrs[i], 20 + i); end
      checks++; if (mem[20 + i] !== pat[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, mem[20 + i], pat[i]); end
    end
  endtask

`ifdef MEM_DMA_FILL_EN
  task automatic test_fill();
    poke(10'd8, 16'h7777);
    run_xfer(10'd0, 10'd5, 10'd3, 1'b1, 16'hBEEF, 0, 0, 8, 1'b0);
    checks++; if (done_cyc !== 4) begin errors++; $display("FAIL fill_done_cyc: got %0d expected 4", done_cyc); end
    checks++; if (wr_count !== 3) begin errors++; $display("FAIL fill_wr_count: got %0d expected 3", wr_count); end
    checks++; if (first_wr_cyc !== 1) begin errors++; $display("FAIL fill_first_wr_cyc: got %0d expected 1", first_wr_cyc); end
    checks++; if (rd_addrs.size() !== 0) begin errors++; $display("FAIL fill_reads: got %0d expected 0", rd_addrs.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[5 + i] !== 16'hBEEF) begin errors++; $display("FAIL fill_data[%0d]: got %h expected beef", 5 + i, mem[5 + i]); end
    end
    checks++; if (mem[8] !== 16'h7777) begin errors++; $display("FAIL fill_untouched8: got %h expected 7777", mem[8]); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
`ifdef MEM_DMA_FILL_EN
    fill = 1'b0; fill_data = '0;
`endif
    test_reset();
    test_copy();
    test_zero_len();
    test_start_while_busy();
    test_reset_abort();
    test_wrap();
`ifdef MEM_DMA_FILL_EN
    test_fill();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
